serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_sub_pkg.sv | 15 +
 rtl/one_bit_full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 138 +++++++++++++
 tb/tb_serial_subtractor.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared FSM state type and counter sizing for serial_subtractor
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // One spare bit so the counter can be compared against WIDTH-1 without wrapping.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/one_bit_full_subtractor.sv
// rtl/one_bit_full_subtractor.sv - single-bit full subtractor computing x - y - bin
module one_bit_full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - LSB-first bit-serial subtractor, one bit per clock.
// Optional signed-overflow output ovf enabled by SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-2:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bor_q, bor_d;
    logic             borrow_out_q, borrow_out_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic             bit_d;
    logic             bit_bout;
    logic [WIDTH-1:0] res_cat;

    one_bit_full_subtractor u_fs (
        .x    (a_sh_q[0]),
        .y    (b_sh_q[0]),
        .bin  (bor_q),
        .d    (bit_d),
        .bout (bit_bout)
    );

    // Current bit joins the partial result at the MSB; on the last bit this is the full difference.
    assign res_cat = {bit_d, res_q};

    always_comb begin
        state_d      = state_q;
        a_sh_d       = a_sh_q;
        b_sh_d       = b_sh_q;
        res_d        = res_q;
        diff_d       = diff_q;
        cnt_d        = cnt_q;
        bor_d        = bor_q;
        borrow_out_d = borrow_out_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ovf_d        = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    res_d   = '0;
                    cnt_d   = '0;
                    bor_d   = 1'b0;
                end
            end
            RUN: begin
                a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
                res_d  = res_cat[WIDTH-1:1];
                bor_d  = bit_bout;
                if (cnt_q == CNT_LAST) begin
                    state_d      = DONE;
                    diff_d       = res_cat;
                    borrow_out_d = bit_bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                    // Operand LSBs now hold the original MSBs.
                    ovf_d        = (a_sh_q[0] != b_sh_q[0]) & (bit_d != a_sh_q[0]);
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            a_sh_q       <= '0;
            b_sh_q       <= '0;
            res_q        <= '0;
            diff_q       <= '0;
            cnt_q        <= '0;
            bor_q        <= 1'b0;
            borrow_out_q <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            a_sh_q       <= a_sh_d;
            b_sh_q       <= b_sh_d;
            res_q        <= res_d;
            diff_q       <= diff_d;
            cnt_q        <= cnt_d;
            bor_q        <= bor_d;
            borrow_out_q <= borrow_out_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf_q        <= ovf_d;
`endif
        end
    end

    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    assign ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor (WIDTH=8)
module tb_serial_subtractor;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] diff;
    logic         borrow_out;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic         ovf;
`endif

    int   passes = 0;
    int   total  = 0;
    int   cyc    = 0;
    int   done_cnt = 0;
    int   done_cyc[$];
    exp_t sb[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ,
        .ovf        (ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t e;
        e.d  = av - bv;
        e.bo = (av < bv);
        e.ov = (av[W-1] != bv[W-1]) && (e.d[W-1] != av[W-1]);
        return e;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            done_cyc.push_back(cyc);
            check("sb_pending_at_done", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("diff", diff, e.d);
                check("borrow_out", borrow_out, e.bo);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                check("ovf", ovf, e.ov);
`endif
            end
        end
    end

    // Drives one operation from IDLE and checks busy/done timing edge by edge.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv);
        @(posedge clk); #1;
        a = av; b = bv; start = 1'b1;
        sb.push_back(model(av, bv));
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        check("busy_after_accept", busy, 1);
        for (int k = 1; k <= W; k++) begin
            @(posedge clk); #1;
            if (k < W) begin
                check("busy_in_run", busy, 1);
                check("no_done_in_run", done, 0);
            end else begin
                check("done_after_last_bit", done, 1);
                check("busy_low_in_done", busy, 0);
            end
        end
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base;
        int seen;
        logic [W-1:0] held;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow_out, 0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        check("rst_ovf", ovf, 0);
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run_op(8'd100, 8'd37);
        check("req032_diff_held", diff, 63);
        run_op(8'd37, 8'd100);
        held = diff;
        check("req033_diff_held", held, 193);
        run_op(8'h80, 8'h01);
        run_op(8'd200, 8'd200);
        run_op(8'd0, 8'd255);

        // start pulse mid-run must be dropped
        base = done_cnt;
        @(posedge clk); #1;
        a = 8'd10; b = 8'd3; start = 1'b1;
        sb.push_back(model(8'd10, 8'd3));
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 a = 8'd200; b = 8'd1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        check("ignored_start_single_done", done_cnt - base, 1);
        check("ignored_start_idle", busy, 0);
        check("ignored_start_result", diff, 7);

        // reset mid-operation
        @(posedge clk); #1;
        a = 8'd9; b = 8'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_diff", diff, 0);
        check("midrst_borrow", borrow_out, 0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        check("midrst_ovf", ovf, 0);
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        base = done_cnt;
        repeat (15) @(posedge clk);
        #1;
        check("no_partial_after_rst", done_cnt - base, 0);
        check("idle_after_rst", busy, 0);
        run_op(8'd5, 8'd5);

        // start held high: back-to-back operations
        base = done_cyc.size();
        @(posedge clk); #1;
        a = 8'd0; b = 8'd255; start = 1'b1;
        for (int i = 0; i < 3; i++) sb.push_back(model(8'd0, 8'd255));
        seen = 0;
        for (int g = 0; g < 60 && seen < 3; g++) begin
            @(negedge clk); #1;
            if (done) begin
                seen++;
                if (seen == 3) start = 1'b0;
            end
        end
        check("b2b_done_count", seen, 3);
        repeat (15) @(posedge clk);
        #1;
        check("b2b_no_extra", done_cyc.size() - base, 3);
        if (done_cyc.size() - base >= 3) begin
            check("b2b_interval_1", done_cyc[base+1] - done_cyc[base], 10);
            check("b2b_interval_2", done_cyc[base+2] - done_cyc[base+1], 10);
        end
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
